// File: rtl/counter_pkg.sv
// Shared constants and helpers for the counter family (up and down variants).
//   DefaultMod : default counting modulus
//   clog2()    : bits needed to hold values 0..value-1
package counter_pkg;

  localparam int unsigned DefaultMod = 8;

  // Usable in parameter/localparam expressions (constant function).
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    int unsigned span;
    width = 0;
    span  = 1;
    while (span < value) begin
      span  = span << 1;
      width = width + 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/d_ff_ar.sv
// Single-bit D flip-flop with asynchronous active-low reset (resets to 0).
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous reset, active low
//   d_i    : next-state input
//   q_o    : registered output
module d_ff_ar (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_o <= 1'b0;
    end else begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/counter_mod_n_down.sv
// Modulo-MOD down counter with parallel load, terminal count and cascade borrow.
// Optional one-shot mode is compiled in with the macro COUNTER_DOWN_ONESHOT_EN:
// the count then stops at 0 and raises a sticky done flag instead of wrapping.
//   clk      : clock, rising edge
//   rst      : asynchronous reset, active low (q=0, done=0)
//   en       : count enable, one decrement per cycle
//   load     : synchronous load strobe, has priority over en
//   load_val : value to load, clamped to MOD-1
//   q        : registered count
//   tc       : high when q==0
//   borrow   : high when q==0, en=1, load=0 (and not done in one-shot mode)
//   done     : one-shot completion flag (constant 0 when one-shot is compiled out)
module counter_mod_n_down
  import counter_pkg::*;
#(
  parameter int unsigned MOD = DefaultMod,
  localparam int unsigned W  = clog2(MOD)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] q,
  output logic         tc,
  output logic         borrow,
  output logic         done
);

  localparam logic [W-1:0] MaxCount = W'(MOD - 1);

`ifdef COUNTER_DOWN_ONESHOT_EN
  localparam logic [W-1:0] WrapCount = '0;
`else
  localparam logic [W-1:0] WrapCount = MaxCount;
`endif

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;
  logic [W-1:0] load_clamped;

  // Widen before comparing so non-power-of-two moduli clamp correctly.
  assign load_clamped = (32'(load_val) >= MOD) ? MaxCount : load_val;

  assign tc = (q_q == '0);
  assign q  = q_q;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = load_clamped;
    end else if (en) begin
      q_d = tc ? WrapCount : (q_q - W'(1));
    end
  end

  for (genvar i = 0; i < int'(W); i++) begin : g_q_bit
    d_ff_ar u_q_ff (
      .clk_i  (clk),
      .rst_ni (rst),
      .d_i    (q_d[i]),
      .q_o    (q_q[i])
    );
  end

`ifdef COUNTER_DOWN_ONESHOT_EN
  logic done_q;
  logic done_d;

  // Sticky: set by an enabled cycle at zero, cleared only by load or reset.
  always_comb begin
    done_d = done_q;
    if (load) begin
      done_d = 1'b0;
    end else if (en && tc) begin
      done_d = 1'b1;
    end
  end

  d_ff_ar u_done_ff (
    .clk_i  (clk),
    .rst_ni (rst),
    .d_i    (done_d),
    .q_o    (done_q)
  );

  assign done   = done_q;
  assign borrow = tc & en & ~load & ~done_q;
`else
  assign done   = 1'b0;
  assign borrow = tc & en & ~load;
`endif

endmodule
